gps_carr_wipeoff_acc: RTL and testbench

- Carrier wipe-off and integrate-and-dump stage that sits directly downstream of the GPS carrier NCO.
- Takes the NCO's 4-bit carrier phase and the matching IF sample, and maps the phase to quantized cos/sin.
- Forms the I/Q mixed products, then accumulates them over a programmable number of samples.
- Dumped I/Q sums feed the code correlators and the carrier loop discriminator.

---
 rtl/gps_carr_wipeoff_acc.sv | 156 +++++++++++++++
 tb/tb_gps_carr_wipeoff_acc.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gps_carr_wipeoff_acc.sv
// GPS carrier wipe-off and integrate-and-dump stage.
// The NCO phase indexes a 16-entry cos/sin table. The IF sample is mixed down to I/Q, and the
// products are summed with saturation over a programmable number of samples.
module gps_carr_wipeoff_acc #(
    parameter int SAMPLE_W = 4,
    parameter int ACC_W    = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] if_sample,
    input  logic [3:0]                 carr_phase,
    input  logic [15:0]                dump_len,
    input  logic                       clr,
    output logic signed [SAMPLE_W+3:0] i_mix,
    output logic signed [SAMPLE_W+3:0] q_mix,
    output logic                       mix_valid,
    output logic signed [ACC_W-1:0]    i_acc,
    output logic signed [ACC_W-1:0]    q_acc,
    output logic                       acc_valid,
    output logic                       acc_ovf,
    output logic [15:0]                sample_cnt
);

    localparam int MW = SAMPLE_W + 4;

    // Quantized carrier table, 16 steps per cycle.
    function automatic logic signed [3:0] cos_lut(input logic [3:0] k);
        case (k)
            4'd0:    cos_lut = 4'sd7;
            4'd1:    cos_lut = 4'sd6;
            4'd2:    cos_lut = 4'sd5;
            4'd3:    cos_lut = 4'sd3;
            4'd4:    cos_lut = 4'sd0;
            4'd5:    cos_lut = -4'sd3;
            4'd6:    cos_lut = -4'sd5;
            4'd7:    cos_lut = -4'sd6;
            4'd8:    cos_lut = -4'sd7;
            4'd9:    cos_lut = -4'sd6;
            4'd10:   cos_lut = -4'sd5;
            4'd11:   cos_lut = -4'sd3;
            4'd12:   cos_lut = 4'sd0;
            4'd13:   cos_lut = 4'sd3;
            4'd14:   cos_lut = 4'sd5;
            default: cos_lut = 4'sd6;
        endcase
    endfunction

    logic signed [SAMPLE_W-1:0] s_q;
    logic signed [3:0]          cos_q, sin_q;
    logic                       v0_q;

    logic signed [ACC_W-1:0]    sum_i_q, sum_q_q;
    logic [15:0]                cnt_q, len_q;
    logic                       ovf_q;

    logic signed [MW-1:0]       s_ext, c_ext, n_ext;
    logic [15:0]                len_first, len_now;
    logic                       last;
    logic signed [ACC_W:0]      wide_i, wide_q;
    logic signed [ACC_W-1:0]    sat_i, sat_q;
    logic                       clamp_i, clamp_q;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    assign s_ext      = MW'(s_q);
    assign c_ext      = MW'(cos_q);
    assign n_ext      = MW'(sin_q);
    assign sample_cnt = cnt_q;

    // Period length bookkeeping and saturating next sums.
    always_comb begin
        len_first = (dump_len == 16'd0) ? 16'd1 : dump_len;
        // The length is sampled only on the first product of a period.
        len_now   = (cnt_q == 16'd0) ? len_first : len_q;
        last      = ((cnt_q + 16'd1) == len_now);
        wide_i    = (ACC_W+1)'(sum_i_q) + (ACC_W+1)'(i_mix);
        wide_q    = (ACC_W+1)'(sum_q_q) + (ACC_W+1)'(q_mix);
        clamp_i   = wide_i[ACC_W] != wide_i[ACC_W-1];
        clamp_q   = wide_q[ACC_W] != wide_q[ACC_W-1];
        sat_i     = clamp_i ? (wide_i[ACC_W] ? SAT_MIN : SAT_MAX) : wide_i[ACC_W-1:0];
        sat_q     = clamp_q ? (wide_q[ACC_W] ? SAT_MIN : SAT_MAX) : wide_q[ACC_W-1:0];
    end

    // Two-stage mixer pipeline: table lookup, then full-precision products.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q       <= '0;
            cos_q     <= '0;
            sin_q     <= '0;
            v0_q      <= 1'b0;
            i_mix     <= '0;
            q_mix     <= '0;
            mix_valid <= 1'b0;
        end else if (clr) begin
            v0_q      <= 1'b0;
            mix_valid <= 1'b0;
        end else begin
            v0_q <= enable & sample_valid;
            if (enable && sample_valid) begin
                s_q   <= if_sample;
                cos_q <= cos_lut(carr_phase);
                sin_q <= cos_lut(carr_phase + 4'd12);
            end
            mix_valid <= v0_q;
            if (v0_q) begin
                i_mix <= s_ext * c_ext;
                q_mix <= -(s_ext * n_ext);
            end
        end
    end

    // Integrate-and-dump with sticky saturation flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_i_q   <= '0;
            sum_q_q   <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            i_acc     <= '0;
            q_acc     <= '0;
            acc_ovf   <= 1'b0;
            acc_valid <= 1'b0;
        end else if (clr) begin
            sum_i_q   <= '0;
            sum_q_q   <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            acc_valid <= 1'b0;
        end else begin
            acc_valid <= 1'b0;
            if (mix_valid) begin
                if (cnt_q == 16'd0) len_q <= len_first;
                if (last) begin
                    i_acc     <= sat_i;
                    q_acc     <= sat_q;
                    acc_ovf   <= ovf_q | clamp_i | clamp_q;
                    acc_valid <= 1'b1;
                    sum_i_q   <= '0;
                    sum_q_q   <= '0;
                    cnt_q     <= '0;
                    ovf_q     <= 1'b0;
                end else begin
                    sum_i_q <= sat_i;
                    sum_q_q <= sat_q;
                    cnt_q   <= cnt_q + 16'd1;
                    ovf_q   <= ovf_q | clamp_i | clamp_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_gps_carr_wipeoff_acc.sv
// Directed bench for gps_carr_wipeoff_acc.
// The stimulus pushes the expected mixer products and dumps into queues. A monitor on the
// falling clock edge pops each entry when the DUT presents it. A second instance with a narrow
// accumulator covers saturation.
module tb_gps_carr_wipeoff_acc;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b0;
    logic              sample_valid = 1'b0;
    logic signed [3:0] if_sample = '0;
    logic [3:0]        carr_phase = '0;
    logic [15:0]       dump_len = 16'd1;
    logic              clr = 1'b0;

    logic signed [7:0]  i_mix, q_mix, i_mix8, q_mix8;
    logic               mix_valid, mix_valid8;
    logic signed [23:0] i_acc, q_acc;
    logic signed [7:0]  i_acc8, q_acc8;
    logic               acc_valid, acc_ovf, acc_valid8, acc_ovf8;
    logic [15:0]        sample_cnt, sample_cnt8;

    typedef struct { int i; int q; } mix_t;
    typedef struct { int i; int q; int ovf; } acc_t;

    mix_t exp_mix[$];
    acc_t exp_acc[$];
    acc_t exp_acc8[$];
    bit   chk8 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cos_tab[16] = '{7, 6, 5, 3, 0, -3, -5, -6, -7, -6, -5, -3, 0, 3, 5, 6};

    gps_carr_wipeoff_acc #(.SAMPLE_W(4), .ACC_W(24)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
        .if_sample(if_sample), .carr_phase(carr_phase), .dump_len(dump_len), .clr(clr),
        .i_mix(i_mix), .q_mix(q_mix), .mix_valid(mix_valid), .i_acc(i_acc), .q_acc(q_acc),
        .acc_valid(acc_valid), .acc_ovf(acc_ovf), .sample_cnt(sample_cnt)
    );

    gps_carr_wipeoff_acc #(.SAMPLE_W(4), .ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
        .if_sample(if_sample), .carr_phase(carr_phase), .dump_len(dump_len), .clr(clr),
        .i_mix(i_mix8), .q_mix(q_mix8), .mix_valid(mix_valid8), .i_acc(i_acc8),
        .q_acc(q_acc8), .acc_valid(acc_valid8), .acc_ovf(acc_ovf8), .sample_cnt(sample_cnt8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input int ph);
        mix_t m;
        enable       = 1'b1;
        sample_valid = 1'b1;
        if_sample    = 4'(s);
        carr_phase   = 4'(ph);
        m.i = s * cos_tab[ph];
        m.q = -(s * cos_tab[(ph + 12) % 16]);
        exp_mix.push_back(m);
        step();
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic push_acc(input int i, input int q, input int ovf);
        acc_t a;
        a.i = i; a.q = q; a.ovf = ovf;
        exp_acc.push_back(a);
    endtask

    task automatic push_acc8(input int i, input int q, input int ovf);
        acc_t a;
        a.i = i; a.q = q; a.ovf = ovf;
        exp_acc8.push_back(a);
    endtask

    // Scoreboard: pop and compare whenever the DUT presents a product or a dump.
    always @(negedge clk) begin
        if (rst) begin
            if (mix_valid) begin
                chk("mix_expected", int'(exp_mix.size() > 0), 1);
                if (exp_mix.size() > 0) begin
                    mix_t m;
                    m = exp_mix.pop_front();
                    chk("i_mix", int'(i_mix), m.i);
                    chk("q_mix", int'(q_mix), m.q);
                end
            end
            if (acc_valid) begin
                chk("dump_expected", int'(exp_acc.size() > 0), 1);
                if (exp_acc.size() > 0) begin
                    acc_t a;
                    a = exp_acc.pop_front();
                    chk("i_acc", int'(i_acc), a.i);
                    chk("q_acc", int'(q_acc), a.q);
                    chk("acc_ovf", int'(acc_ovf), a.ovf);
                end
            end
            if (chk8 && acc_valid8) begin
                chk("dump8_expected", int'(exp_acc8.size() > 0), 1);
                if (exp_acc8.size() > 0) begin
                    acc_t a;
                    a = exp_acc8.pop_front();
                    chk("i_acc8", int'(i_acc8), a.i);
                    chk("q_acc8", int'(q_acc8), a.q);
                    chk("acc_ovf8", int'(acc_ovf8), a.ovf);
                end
            end
        end
    end

    initial begin
        // Reset state.
        #3;
        chk("rst_i_mix", int'(i_mix), 0);
        chk("rst_mix_valid", int'(mix_valid), 0);
        chk("rst_i_acc", int'(i_acc), 0);
        chk("rst_acc_valid", int'(acc_valid), 0);
        chk("rst_sample_cnt", int'(sample_cnt), 0);
        step();
        rst = 1'b1;
        step();

        // Phase 0, in-phase path; dump two edges after the 4th capture.
        dump_len = 16'd4;
        push_acc(84, 0, 0);
        for (int k = 0; k < 4; k++) send(3, 0);
        chk("t1_cnt_mid", int'(sample_cnt), 2);
        idle(1);
        chk("t1_no_early_dump", int'(acc_valid), 0);
        idle(1);
        chk("t1_dump_time", int'(acc_valid), 1);
        chk("t1_cnt_after", int'(sample_cnt), 0);
        idle(1);
        chk("t1_pulse_width", int'(acc_valid), 0);
        chk("t1_hold_i_acc", int'(i_acc), 84);

        // Quadrature path.
        dump_len = 16'd2;
        push_acc(0, -42, 0);
        send(3, 4);
        send(3, 4);
        idle(3);

        // Phase sweep; the table is zero-mean.
        dump_len = 16'd16;
        push_acc(0, 0, 0);
        for (int k = 0; k < 16; k++) send(-8, k);
        idle(3);

        // Saturation on the narrow instance, then a clean period.
        clr = 1'b1;
        step();
        clr  = 1'b0;
        chk8 = 1'b1;
        dump_len = 16'd4;
        push_acc(224, 0, 0);
        push_acc8(127, 0, 1);
        push_acc(28, 0, 0);
        push_acc8(28, 0, 0);
        for (int k = 0; k < 4; k++) send(-8, 8);
        for (int k = 0; k < 4; k++) send(1, 0);
        idle(4);
        chk("sat_drained", exp_acc8.size(), 0);
        chk8 = 1'b0;

        // Gapped valids: exactly one dump after the third.
        dump_len = 16'd3;
        push_acc(42, 0, 0);
        send(2, 0);
        idle(1);
        send(2, 0);
        idle(1);
        send(2, 0);
        idle(4);

        // Enable low mid-period stalls the count and produces no dump.
        push_acc(21, 0, 0);
        send(1, 0);
        send(1, 0);
        enable       = 1'b0;
        sample_valid = 1'b1;
        for (int k = 0; k < 5; k++) step();
        chk("en_stall_cnt", int'(sample_cnt), 2);
        chk("en_no_dump", exp_acc.size(), 1);
        send(1, 0);
        idle(3);
        chk("en_dump_done", exp_acc.size(), 0);

        // clr with two products in flight and five accumulated.
        dump_len = 16'd10;
        for (int k = 0; k < 7; k++) send(1, 0);
        chk("clr_cnt_before", int'(sample_cnt), 5);
        sample_valid = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        exp_mix.delete();
        chk("clr_cnt", int'(sample_cnt), 0);
        chk("clr_mix_killed", int'(mix_valid), 0);
        idle(3);
        chk("clr_cnt_hold", int'(sample_cnt), 0);
        chk("clr_i_acc_held", int'(i_acc), 21);

        // Asynchronous reset mid-period.
        dump_len = 16'd4;
        send(1, 0);
        send(1, 0);
        send(1, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_i_mix", int'(i_mix), 0);
        chk("arst_mix_valid", int'(mix_valid), 0);
        chk("arst_i_acc", int'(i_acc), 0);
        chk("arst_acc_ovf", int'(acc_ovf), 0);
        chk("arst_sample_cnt", int'(sample_cnt), 0);
        exp_mix.delete();
        sample_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();

        // dump_len of zero behaves as one.
        dump_len = 16'd0;
        push_acc(-7, 0, 0);
        push_acc(14, 0, 0);
        send(-1, 0);
        send(2, 0);
        idle(4);

        chk("mix_queue_empty", exp_mix.size(), 0);
        chk("acc_queue_empty", exp_acc.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Bound the run in case the stimulus stalls.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
